// File: rtl/keypad_scan_debounce_if.sv
// Keypad bus between the matrix scanner and the game core:
// a debounced one-hot key code plus its valid level and new-press strobe.
interface keypad_scan_debounce_if;
  logic [7:0] keypad;
  logic       key_valid;
  logic       key_strobe;

  modport master (output keypad, key_valid, key_strobe);
  modport slave  (input  keypad, key_valid, key_strobe);
endinterface

// File: rtl/keypad_scan_debounce.sv
// Scans the 2x4 whack-a-mole button matrix, debounces whole frames and publishes
// a registered one-hot key code with a single strobe per new press.
module keypad_scan_debounce #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                    clk,
  input  logic                    RESET,
  output logic [3:0]              COL_OUT,
  input  logic [1:0]              ROW_IN,
  keypad_scan_debounce_if.master  kp
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {COL0, COL1, COL2, COL3} state_t;

  state_t          state_reg, state_next;
  logic [DW-1:0]   dwell_reg, dwell_next;
  logic [7:0]      frame_reg, frame_cur;
  logic [7:0]      cand_reg, cand_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [7:0]      deb_reg, deb_next;
  logic [7:0]      keypad_reg, enc;
  logic            strobe_reg;
  logic            sample;
  logic            frame_end;
  logic [1:0]      col_idx;

  // Scan FSM: state register
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_reg <= COL0;
      dwell_reg <= '0;
    end else begin
      state_reg <= state_next;
      dwell_reg <= dwell_next;
    end
  end

  // Scan FSM: next state; rows are sampled only on the last dwell cycle of a column
  always_comb begin
    state_next = state_reg;
    dwell_next = dwell_reg + DW'(1);
    sample     = 1'b0;
    frame_end  = 1'b0;
    col_idx    = 2'd0;
    case (state_reg)
      COL0: col_idx = 2'd0;
      COL1: col_idx = 2'd1;
      COL2: col_idx = 2'd2;
      COL3: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
    if (dwell_reg == DW'(SCAN_DIV - 1)) begin
      dwell_next = '0;
      sample     = 1'b1;
      case (state_reg)
        COL0: state_next = COL1;
        COL1: state_next = COL2;
        COL2: state_next = COL3;
        COL3: begin
          state_next = COL0;
          frame_end  = 1'b1;
        end
        default: state_next = COL0;
      endcase
    end
  end

  assign COL_OUT = 4'b0001 << col_idx;

  // Frame including the sample taken this cycle, so frame end sees the complete frame
  always_comb begin
    frame_cur = frame_reg;
    if (sample) begin
      frame_cur[{1'b0, col_idx}] = ROW_IN[0];
      frame_cur[{1'b1, col_idx}] = ROW_IN[1];
    end
  end

  always_comb begin
    cand_next = cand_reg;
    cnt_next  = cnt_reg;
    deb_next  = deb_reg;
    if (frame_end) begin
      if (frame_cur != cand_reg) begin
        cand_next = frame_cur;
        cnt_next  = CW'(1);
        if (DEBOUNCE_SCANS == 1)
          deb_next = frame_cur;
      end else if (cnt_reg < CW'(DEBOUNCE_SCANS)) begin
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == CW'(DEBOUNCE_SCANS - 1))
          deb_next = cand_reg;
      end
    end
  end

  // Multi-press (more than one bit) is ambiguous and must never score a hit
  always_comb begin
    enc = 8'h00;
    if ((deb_reg != 8'h00) && ((deb_reg & (deb_reg - 8'h01)) == 8'h00))
      enc = deb_reg;
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      frame_reg  <= '0;
      cand_reg   <= '0;
      cnt_reg    <= '0;
      deb_reg    <= '0;
      keypad_reg <= '0;
      strobe_reg <= 1'b0;
    end else begin
      frame_reg  <= frame_cur;
      cand_reg   <= cand_next;
      cnt_reg    <= cnt_next;
      deb_reg    <= deb_next;
      keypad_reg <= enc;
      strobe_reg <= (enc != 8'h00) && (enc != keypad_reg);
    end
  end

  assign kp.keypad     = keypad_reg;
  assign kp.key_valid  = |keypad_reg;
  assign kp.key_strobe = strobe_reg;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Scoreboard bench for keypad_scan_debounce: a button-matrix model drives ROW_IN from
// COL_OUT; expected keypad codes are queued by the stimulus and popped by a monitor.
module tb_keypad_scan_debounce;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] COL_OUT;
  logic [1:0] ROW_IN;
  logic [7:0] keys = 8'h00;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  logic       mon_en = 1'b0;
  logic [7:0] prev_keypad = 8'h00;

  keypad_scan_debounce_if kif ();

  keypad_scan_debounce #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk     (clk),
    .RESET   (RESET),
    .COL_OUT (COL_OUT),
    .ROW_IN  (ROW_IN),
    .kp      (kif.master)
  );

  always #5 clk = ~clk;

  assign ROW_IN[0] = |(keys[3:0] & COL_OUT);
  assign ROW_IN[1] = |(keys[7:4] & COL_OUT);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every change of keypad pops one expected code
  always @(negedge clk) begin
    if (mon_en) begin
      if (kif.keypad !== prev_keypad) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_keypad_change", {24'h0, kif.keypad}, {24'h0, prev_keypad});
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("keypad_code", {24'h0, kif.keypad}, {24'h0, e});
          chk("key_valid", {31'h0, kif.key_valid}, {31'h0, (e != 8'h00)});
          chk("key_strobe_on_change", {31'h0, kif.key_strobe}, {31'h0, (e != 8'h00)});
        end
        $display("keypad %02h -> %02h strobe=%0b", prev_keypad, kif.keypad, kif.key_strobe);
        prev_keypad = kif.keypad;
      end else if (kif.key_strobe) begin
        chk("spurious_strobe", {31'h0, kif.key_strobe}, 32'h0);
      end
    end
  end

  task automatic wait_frames(input int n);
    repeat (n * 16) @(posedge clk);
  endtask

  // Counts edges from reset release to the first nonzero keypad, bounded
  task automatic latency_check(input string name);
    int cnt;
    cnt = 0;
    while (cnt < 200) begin
      @(posedge clk);
      cnt++;
      #1;
      if (kif.keypad != 8'h00) break;
    end
    chk(name, cnt, 49);
  endtask

  initial begin
    // Test 1: reset mid-frame, then column walk
    repeat (2) @(negedge clk);
    RESET = 1'b0;
    mon_en = 1'b1;
    repeat (7) @(posedge clk);
    #2 RESET = 1'b1;
    #1;
    chk("reset_col_out", {28'h0, COL_OUT}, 32'h1);
    chk("reset_keypad", {24'h0, kif.keypad}, 32'h0);
    chk("reset_strobe", {31'h0, kif.key_strobe}, 32'h0);
    @(negedge clk);
    RESET = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("col_walk", {28'h0, COL_OUT}, 32'h1 << ((i / 4) % 4));
      @(negedge clk);
    end

    // Test 2: key 6 held from frame start, exact latency, no repeat strobes
    @(posedge clk);
    #2 RESET = 1'b1;
    keys = 8'h40;
    exp_q.push_back(8'h40);
    @(negedge clk);
    RESET = 1'b0;
    latency_check("latency_key6");
    wait_frames(10);
    keys = 8'h00;
    exp_q.push_back(8'h00);
    wait_frames(5);

    // Test 3: key 0 bouncing every 5 cycles for 2 frames, then stable
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i % 5 == 0) keys[0] = ~keys[0];
    end
    keys = 8'h01;
    exp_q.push_back(8'h01);
    wait_frames(5);
    chk("bounce_settled", {24'h0, kif.keypad}, 32'h01);
    keys = 8'h00;
    exp_q.push_back(8'h00);
    wait_frames(5);

    // Test 4: keys 1 and 5 together are ambiguous; release 5 gives key 1
    keys = 8'h22;
    wait_frames(6);
    chk("multi_press_keypad", {24'h0, kif.keypad}, 32'h0);
    keys = 8'h02;
    exp_q.push_back(8'h02);
    wait_frames(5);

    // Test 5: key 3 then direct switch to key 4, then release
    keys = 8'h08;
    exp_q.push_back(8'h08);
    wait_frames(5);
    keys = 8'h10;
    exp_q.push_back(8'h10);
    wait_frames(5);
    keys = 8'h00;
    exp_q.push_back(8'h00);
    wait_frames(5);
    chk("release_key_valid", {31'h0, kif.key_valid}, 32'h0);

    // Test 6: reset while key 7 is committed
    keys = 8'h80;
    exp_q.push_back(8'h80);
    wait_frames(5);
    chk("key7_committed", {24'h0, kif.keypad}, 32'h80);
    exp_q.push_back(8'h00);
    @(posedge clk);
    #2 RESET = 1'b1;
    #1;
    chk("reset_clears_keypad", {24'h0, kif.keypad}, 32'h0);
    chk("reset_clears_valid", {31'h0, kif.key_valid}, 32'h0);
    chk("reset_col_out_again", {28'h0, COL_OUT}, 32'h1);
    exp_q.push_back(8'h80);
    @(negedge clk);
    RESET = 1'b0;
    latency_check("latency_key7");
    wait_frames(3);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
